// File: rtl/f32_mult.sv
`default_nettype none
// ============================================================================
// f32_mult : sequential binary32 multiplier, 24-cycle shift-add, RNE, FTZ
// Revision : 1.0
// ============================================================================
module f32_mult (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        start,
    output logic        done,
    output logic [31:0] p,
    output logic        underflow_o,
    output logic        overflow_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_UNPACK = 3'd1;
    localparam logic [2:0] S_MULT   = 3'd2;
    localparam logic [2:0] S_NORM   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    logic [2:0]  state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic        sign_q, sign_d;
    logic [7:0]  ea_q, ea_d, eb_q, eb_d;
    logic [47:0] mcand_q, mcand_d;
    logic [23:0] mplier_q, mplier_d;
    logic [47:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        nan_q, nan_d, inf_q, inf_d, zero_q, zero_d;
    logic [31:0] p_q, p_d;
    logic        done_q, done_d, ovf_q, ovf_d, unf_q, unf_d;

    // Operand classification, used only in UNPACK.
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    always_comb begin
        a_zero = (a_q[30:23] == 8'd0);
        b_zero = (b_q[30:23] == 8'd0);
        a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
        b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
        a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
        b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
    end

    // Normalisation and round-to-nearest-even on the finished 48-bit product.
    logic [22:0] mant;
    logic        guard, rnd, sticky, round_up;
    logic [23:0] mant_rnd;
    logic [9:0]  exp_pre, exp_rnd;
    always_comb begin
        if (acc_q[47]) begin
            mant   = acc_q[46:24];
            guard  = acc_q[23];
            rnd    = acc_q[22];
            sticky = |acc_q[21:0];
        end else begin
            mant   = acc_q[45:23];
            guard  = acc_q[22];
            rnd    = acc_q[21];
            sticky = |acc_q[20:0];
        end
        round_up = guard & (rnd | sticky | mant[0]);
        mant_rnd = {1'b0, mant} + {23'd0, round_up};
        exp_pre  = {2'b00, ea_q} + {2'b00, eb_q} - 10'd127 + {9'd0, acc_q[47]};
        // A carry out leaves the fraction all-zero, so only the exponent moves.
        exp_rnd  = exp_pre + {9'd0, mant_rnd[23]};
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_d   = sign_q;
        ea_d     = ea_q;
        eb_d     = eb_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        nan_d    = nan_q;
        inf_d    = inf_q;
        zero_d   = zero_q;
        p_d      = p_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    p_d     = 32'd0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                sign_d   = a_q[31] ^ b_q[31];
                ea_d     = a_q[30:23];
                eb_d     = b_q[30:23];
                mcand_d  = a_zero ? 48'd0 : {24'd0, 1'b1, a_q[22:0]};
                mplier_d = b_zero ? 24'd0 : {1'b1, b_q[22:0]};
                acc_d    = 48'd0;
                cnt_d    = 5'd0;
                nan_d    = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
                inf_d    = a_inf | b_inf;
                zero_d   = a_zero | b_zero;
                state_d  = S_MULT;
            end
            S_MULT: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd23) state_d = S_NORM;
            end
            S_NORM: begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
                if (nan_q) begin
                    p_d = QNAN;
                end else if (inf_q) begin
                    p_d = {sign_q, 8'hFF, 23'd0};
                end else if (zero_q) begin
                    p_d = {sign_q, 31'd0};
                end else if ($signed(exp_rnd) >= $signed(10'sd255)) begin
                    p_d   = {sign_q, 8'hFF, 23'd0};
                    ovf_d = 1'b1;
                end else if ($signed(exp_rnd) <= $signed(10'sd0)) begin
                    p_d   = {sign_q, 31'd0};
                    unf_d = 1'b1;
                end else begin
                    p_d = {sign_q, exp_rnd[7:0], mant_rnd[22:0]};
                end
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            sign_q   <= 1'b0;
            ea_q     <= 8'd0;
            eb_q     <= 8'd0;
            mcand_q  <= 48'd0;
            mplier_q <= 24'd0;
            acc_q    <= 48'd0;
            cnt_q    <= 5'd0;
            nan_q    <= 1'b0;
            inf_q    <= 1'b0;
            zero_q   <= 1'b0;
            p_q      <= 32'd0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_q   <= sign_d;
            ea_q     <= ea_d;
            eb_q     <= eb_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            nan_q    <= nan_d;
            inf_q    <= inf_d;
            zero_q   <= zero_d;
            p_q      <= p_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign done        = done_q;
    assign p           = p_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_f32_mult.sv
`default_nettype none
// ============================================================================
// tb_f32_mult : directed-vector bench for the f32_mult sequential multiplier
// Revision    : 1.0
// ============================================================================
module tb_f32_mult;

    localparam int NVEC    = 18;
    localparam int LATENCY = 26;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        done;
    logic [31:0] p;
    logic        underflow_o;
    logic        overflow_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vecs [NVEC];

    f32_mult dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a),
        .b           (b),
        .start       (start),
        .done        (done),
        .p           (p),
        .underflow_o (underflow_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Pulse start for exactly one accepting edge; returns 1 time unit after it.
    task automatic issue(input logic [31:0] aa, input logic [31:0] bb);
        @(negedge clk);
        a = aa;
        b = bb;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int ndone;
        int first_at;
        int second_at;
        logic [31:0] p_first;

        vecs[0]  = '{32'h3F800000, 32'h40000000, 32'h40000000, 1'b0, 1'b0};
        vecs[1]  = '{32'h40400000, 32'hC0000000, 32'hC0C00000, 1'b0, 1'b0};
        vecs[2]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0, 1'b0};
        vecs[3]  = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 1'b0, 1'b0};
        vecs[4]  = '{32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1, 1'b0};
        vecs[5]  = '{32'hFF000000, 32'h7F000000, 32'hFF800000, 1'b1, 1'b0};
        vecs[6]  = '{32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1};
        vecs[7]  = '{32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1'b0};
        vecs[8]  = '{32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b0};
        vecs[9]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0};
        vecs[10] = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0};
        vecs[11] = '{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0};
        vecs[12] = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0};
        // Exact tie, even LSB: rounds down.
        vecs[13] = '{32'h3F800800, 32'h3F800800, 32'h3F801000, 1'b0, 1'b0};
        // Guard plus sticky: rounds up.
        vecs[14] = '{32'h3F800801, 32'h3F800801, 32'h3F801003, 1'b0, 1'b0};
        // Exact tie, odd LSB: rounds up to even.
        vecs[15] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 1'b0, 1'b0};
        vecs[16] = '{32'h3F800000, 32'hFF800000, 32'hFF800000, 1'b0, 1'b0};
        vecs[17] = '{32'h00000000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b0};

        #1;
        chk("reset_p", p, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_ovf", {31'd0, overflow_o}, 32'd0);
        chk("reset_unf", {31'd0, underflow_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < NVEC; v++) begin
            issue(vecs[v].a, vecs[v].b);
            chk($sformatf("v%0d_cleared_p", v), p, 32'd0);
            wait_done(n);
            chk($sformatf("v%0d_latency", v), n, LATENCY);
            chk($sformatf("v%0d_p", v), p, vecs[v].p);
            chk($sformatf("v%0d_ovf", v), {31'd0, overflow_o}, {31'd0, vecs[v].ovf});
            chk($sformatf("v%0d_unf", v), {31'd0, underflow_o}, {31'd0, vecs[v].unf});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", v), {31'd0, done}, 32'd0);
            chk($sformatf("v%0d_p_held", v), p, vecs[v].p);
        end

        // Second start during MULT must be ignored.
        issue(32'h3FC00000, 32'h3FC00000);
        ndone = 0;
        first_at = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (i == 10) begin
                a = 32'h7F000000;
                b = 32'h40000000;
                start = 1'b1;
            end else if (i == 11) begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                if (first_at < 0) begin
                    first_at = i;
                    p_first = p;
                end
            end
        end
        chk("busy_start_done_count", ndone, 1);
        chk("busy_start_latency", first_at, LATENCY);
        chk("busy_start_p", p_first, 32'h40100000);
        chk("busy_start_ovf", {31'd0, overflow_o}, 32'd0);

        // start held high through DONE restarts on the edge after returning to IDLE.
        @(negedge clk);
        a = 32'h3F800000;
        b = 32'h40000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        first_at = -1;
        second_at = -1;
        for (int i = 1; i <= 70; i++) begin
            @(posedge clk);
            #1;
            if (i == 27) a = 32'h40400000;
            if (i == 60) start = 1'b0;
            if (done) begin
                if (first_at < 0) begin
                    first_at = i;
                    p_first = p;
                end else if (second_at < 0) begin
                    second_at = i;
                    chk("held_start_p2", p, 32'h40C00000);
                end
            end
        end
        chk("held_start_first", first_at, LATENCY);
        chk("held_start_p1", p_first, 32'h40000000);
        chk("held_start_second", second_at, 2 * LATENCY + 2);

        // Reset mid-MULT aborts the operation.
        issue(32'h3F800000, 32'h40000000);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_p", p, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_ovf", {31'd0, overflow_o}, 32'd0);
        chk("midrst_unf", {31'd0, underflow_o}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ndone = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("midrst_no_done", ndone, 0);

        // Reset during DONE clears the registered result without waiting for a clock.
        issue(32'h7F000000, 32'h40000000);
        wait_done(n);
        chk("donerst_pre_p", p, 32'h7F800000);
        #1 rst_n = 1'b0;
        #1;
        chk("donerst_p", p, 32'd0);
        chk("donerst_done", {31'd0, done}, 32'd0);
        chk("donerst_ovf", {31'd0, overflow_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(32'h40400000, 32'hC0000000);
        wait_done(n);
        chk("post_rst_latency", n, LATENCY);
        chk("post_rst_p", p, 32'hC0C00000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/f32_mult.md
Name: f32_mult

Overview:
- Sequential IEEE-754 single-precision multiplier: p = a × b.
- Uses a 24-iteration shift-add mantissa datapath with a start/done handshake and overflow/underflow status flags.
- Sits as a shared arithmetic unit behind a controller that issues one operation at a time and waits for done.

Parameters:
- None. Format is fixed to binary32: 1 sign bit, 8 exponent bits, 23 fraction bits.

Ports:
- clk  input  1  Clock; all state updates on the rising edge.
- rst_n  input  1  Reset. Asynchronous, active-low.
- a  input  32  Operand A, binary32. Sampled only on the edge that accepts start.
- b  input  32  Operand B, binary32. Sampled only on the edge that accepts start.
- start  input  1  Begin operation. Honoured only in IDLE; ignored while busy.
- done  output  1  One-cycle pulse: p and the flags are valid.
- p  output  32  Product, binary32. Registered, and held until the next accepted start.
- underflow_o  output  1  Result was flushed to zero because of exponent underflow. Registered with p.
- overflow_o  output  1  Result saturated to infinity because of exponent overflow. Registered with p.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; p=0, done=0, underflow_o=0, overflow_o=0; internal registers cleared.
  - Reset during an operation aborts it; no done is produced.
- FSM: IDLE -> UNPACK (1 cycle) -> MULT (24 cycles) -> NORM (1 cycle) -> DONE (1 cycle) -> IDLE.
- Timing:
  - Edge k, in IDLE with start=1: latch a and b; go to UNPACK.
  - NORM edge (k+26): p and flags are written.
  - done=1 during the DONE cycle only (after edge k+26); all other cycles done=0.
  - Latency is fixed at 26 edges for every operand class, special cases included.
  - start held high through DONE begins a new operation on the edge after DONE returns to IDLE.
- UNPACK:
  - Sign = sa XOR sb.
  - Mantissa = {1, frac} for normal operands.
  - Operands with exponent 0 (zero or subnormal) are treated as signed zero (flush-to-zero inputs).
  - Classify NaN, Inf, and zero.
- MULT:
  - Unsigned shift-add of two 24-bit mantissas into a 48-bit product, one multiplier bit per cycle.
  - Runs even for special cases; the result is overridden in NORM.
- NORM:
  - If product bit 47 is set: mantissa = bits 46:24 and exp = ea+eb-126.
  - Otherwise: mantissa = bits 45:23 and exp = ea+eb-127.
  - Compute exp in signed 10-bit arithmetic.
  - Round to nearest, ties to even, using guard, round and sticky bits from the remaining low bits.
  - A rounding carry out of the mantissa renormalises it and increments exp.
- Range checks, after rounding:
  - exp ≥ 255: p = {sign, 8'hFF, 23'h0}, overflow_o=1.
  - exp ≤ 0: p = {sign, 31'h0}, underflow_o=1. No subnormal outputs are produced.
- Special cases, in priority order (all have overflow_o=0 and underflow_o=0):
  - Either input NaN, or Inf × zero: p = 32'h7FC00000.
  - Either input Inf: p = {sign, 8'hFF, 23'h0}.
  - Either input zero (including flushed subnormals): p = {sign, 31'h0}.
- Flags and p are cleared to 0 on the edge that accepts start. They are rewritten at NORM.

Test Plan:
- Basic product: a=3F800000, b=40000000 -> done 26 edges after start; p=40000000, flags 0. Then a=40400000, b=C0000000 -> p=C0C00000.
- Rounding: a=3F800001, b=3F800001 -> p=3F800002 (RNE drops the 2^-46 term). Also a=3FFFFFFF, b=3FFFFFFF -> p=407FFFFE.
- Overflow: a=7F000000, b=40000000 -> p=7F800000, overflow_o=1. Also a=FF000000, b=7F000000 -> p=FF800000, overflow_o=1.
- Underflow and zero handling:
  - a=00800000, b=00800000 -> p=00000000, underflow_o=1.
  - a=80000000, b=3F800000 -> p=80000000, underflow_o=0.
  - Subnormal input a=00000001, b=3F800000 -> p=00000000.
- Specials:
  - a=7F800000, b=00000000 -> p=7FC00000.
  - a=7FC00000, b=3F800000 -> p=7FC00000.
  - a=FF800000, b=40000000 -> p=FF800000.
- Handshake and reset:
  - A second start pulse during MULT is ignored, and done pulses exactly once.
  - Asserting rst_n=0 mid-MULT clears p, done and flags immediately; no done follows.
  - A subsequent start completes normally.
